seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.
//  Steps a 3-bit digit index and drives the active-low anode selects (one-hot-low) and the active-low segments.
//  Inserts a blanking interval between digits to suppress ghosting.
//  Accepts new display data through a valid/ready handshake and applies it only at frame boundaries.
// PARAMETERS
//  DIV_MAX       99999  cycles per digit slot minus 1 (slot = DIV_MAX+1 clk cycles)
//  BLANK_CYCLES  1000   cycles at start of each slot with all anodes off; legal range 0..DIV_MAX-1
// PORTS
//  clk         in   1   system clock; the only clock
//  rst_n       in   1   asynchronous, active-low reset
//  load_valid  in   1   source offers data_in/dp_in/en_in
//  load_ready  out  1   1 = pending buffer empty, offer will be taken
//  data_in     in   32  8 hex nibbles; digit k = data_in[4k+3:4k]
//  dp_in       in   8   decimal point per digit, 1 = lit
//  en_in       in   8   digit enable, 0 = digit dark for its slot
//  an          out  8   anode selects, active low
//  seg         out  7   segments {g,f,e,d,c,b,a}, active low
//  dp          out  1   decimal point, active low
//  frame_tick  out  1   1-cycle pulse after each frame wrap (digit 7 -> 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, load_ready=1, idx=0, cnt=0.
//    Active and pending regs are cleared (active en=0, so the display stays dark until the first load).
//    Pending data is discarded. Outputs are forced immediately, not at the next edge.
//  - Counter cnt runs 0..DIV_MAX.
//    On cnt==DIV_MAX: cnt<=0 and idx<=idx+1, wrapping 7->0.
//  - Slot phase: BLANK while cnt<BLANK_CYCLES, DRIVE otherwise. BLANK_CYCLES=0 means no BLANK phase.
//  - Outputs are registered from (phase, idx, active regs), giving 1 cycle of latency from counter state.
//      BLANK: an=8'hFF, seg=7'h7F, dp=1.
//      DRIVE: an=~(8'b1<<idx) if en_act[idx], else 8'hFF.
//             seg=font(data_act[4idx+:4]); dp=~dp_act[idx].
//  - Font, active low {g..a}:
//      0=1000000  1=1111001  2=0100100  3=0110000  4=0011001  5=0010010  6=0000010  7=1111000
//      8=0000000  9=0010000  A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//  - Frame boundary = cycle where cnt==DIV_MAX and idx==7.
//      On that edge, if pending is full: active<=pending and pending is cleared.
//      load_ready is 1 from the next cycle.
//      frame_tick=1 for exactly the cycle after the boundary.
//  - Handshake:
//      Transfer when load_valid & load_ready; data goes into pending and load_ready drops next cycle.
//      The source holds its data while ready=0. There is no overflow: ready=1 implies pending is empty.
//  - Simultaneous events:
//      Accept on the boundary cycle (pending empty): data goes to pending and reaches active at the NEXT boundary.
//      Accepted data always appears at the first boundary strictly after the accept cycle.
//      A boundary with pending full and load_valid=1 frees pending only; no accept that cycle, since ready was 0.
// STRUCTURE
//  - Shared header seg7_defs.vh (package-equivalent) holds:
//      SEG7_NUM_DIGITS=8, SEG7_AN_OFF=8'hFF, SEG7_SEG_BLANK=7'h7F, the 16 font constants.
//  - One sub-module, seg_hex_decoder: combinational 4-bit nibble -> 7-bit active-low font.
//  - Top contains:
//      cnt/idx counters
//      phase decode
//      pending/active register pairs with the pending-full flag
//      output registers
// TESTING (bench params DIV_MAX=9, BLANK_CYCLES=2, so 10-cycle slots and 80-cycle frames)
//  1. rst_n=0 for 3 cycles
//     -> an=FF, seg=7F, dp=1, load_ready=1, frame_tick=0.
//     After release with no load, an stays FF through 2 frames.
//  2. Load data=32'h76543210, dp=8'h01, en=8'hFF
//     -> from the following frame, slot k: 2 cycles an=FF, then 8 cycles an=~(1<<k), seg=font(k).
//     dp=0 only in slot 0. frame_tick pulses every 80 cycles.
//  3. Second load_valid while pending full
//     -> load_ready=0 until the cycle after the boundary, then accept.
//     Old data still shown for the current frame.
//  4. load_valid asserted exactly on the boundary cycle (pending empty)
//     -> new value is not shown in the next frame; it is shown in the frame after.
//  5. en=8'h0F, data=32'hFFFFFFFF
//     -> slots 4-7 an=FF for all 10 cycles; slots 0-3 seg=0001110.
//  6. Assert rst_n=0 mid-DRIVE of digit 5
//     -> an=FF and seg=7F in the same cycle with no clock edge.
//     After release: restart at idx 0 in BLANK, display dark until reloaded.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared constants and font table for the 7-segment scan controller
package seg7_scan_ctrl_pkg;

  localparam int         SEG7_NUM_DIGITS = 8;
  localparam logic [7:0] SEG7_AN_OFF     = 8'hFF;
  localparam logic [6:0] SEG7_SEG_BLANK  = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] FONT_0 = 7'b1000000;
  localparam logic [6:0] FONT_1 = 7'b1111001;
  localparam logic [6:0] FONT_2 = 7'b0100100;
  localparam logic [6:0] FONT_3 = 7'b0110000;
  localparam logic [6:0] FONT_4 = 7'b0011001;
  localparam logic [6:0] FONT_5 = 7'b0010010;
  localparam logic [6:0] FONT_6 = 7'b0000010;
  localparam logic [6:0] FONT_7 = 7'b1111000;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0010000;
  localparam logic [6:0] FONT_A = 7'b0001000;
  localparam logic [6:0] FONT_B = 7'b0000011;
  localparam logic [6:0] FONT_C = 7'b1000110;
  localparam logic [6:0] FONT_D = 7'b0100001;
  localparam logic [6:0] FONT_E = 7'b0000110;
  localparam logic [6:0] FONT_F = 7'b0001110;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seg7_scan_ctrl_seg_hex_decoder.sv
// rtl/seg7_scan_ctrl_seg_hex_decoder.sv - combinational hex nibble to active-low 7-segment font
module seg_hex_decoder
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] font
);

  always_comb begin
    font = SEG7_SEG_BLANK;
    case (nibble)
      4'h0: font = FONT_0;
      4'h1: font = FONT_1;
      4'h2: font = FONT_2;
      4'h3: font = FONT_3;
      4'h4: font = FONT_4;
      4'h5: font = FONT_5;
      4'h6: font = FONT_6;
      4'h7: font = FONT_7;
      4'h8: font = FONT_8;
      4'h9: font = FONT_9;
      4'hA: font = FONT_A;
      4'hB: font = FONT_B;
      4'hC: font = FONT_C;
      4'hD: font = FONT_D;
      4'hE: font = FONT_E;
      4'hF: font = FONT_F;
      default: font = SEG7_SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit multiplexed 7-segment scanner with blanking and frame-aligned load
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIV_MAX      = 99999,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [31:0]                data_in,
  input  logic [7:0]                 dp_in,
  input  logic [7:0]                 en_in,
  output logic [SEG7_NUM_DIGITS-1:0] an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic                       frame_tick
);

  localparam int               CNT_W    = $clog2(DIV_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  phase_e           phase;
  logic             slot_end;
  logic             boundary;
  logic             accept;

  logic             pend_full;
  logic [31:0]      pend_data, act_data;
  logic [7:0]       pend_dp, act_dp;
  logic [7:0]       pend_en, act_en;
  logic [6:0]       font;

  always_comb begin
    slot_end = (cnt == CNT_LAST);
    boundary = slot_end && (idx == 3'd7);
    accept   = load_valid && !pend_full;
    // Signed compare keeps BLANK_CYCLES=0 meaning "no blank phase" without a constant-compare.
    phase    = (int'(cnt) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
  end

  assign load_ready = !pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending can only be filled while empty, so a boundary transfer and an accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
    end else if (boundary && pend_full) begin
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      act_en    <= pend_en;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_data <= data_in;
      pend_dp   <= dp_in;
      pend_en   <= en_in;
      pend_full <= 1'b1;
    end
  end

  seg_hex_decoder u_dec (
    .nibble(act_data[{idx, 2'b00} +: 4]),
    .font  (font)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= SEG7_AN_OFF;
      seg        <= SEG7_SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (phase == PH_DRIVE) begin
        an  <= act_en[idx] ? ~(8'b1 << idx) : SEG7_AN_OFF;
        seg <= font;
        dp  <= ~act_dp[idx];
      end else begin
        an  <= SEG7_AN_OFF;
        seg <= SEG7_SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl with 10-cycle slots
module tb_seg7_scan_ctrl;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en_in = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_ctrl #(.DIV_MAX(SLOT - 1), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  e;
  } ent_t;

  ent_t sb[$];
  ent_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] font_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // cyc = k while the DUT counter holds state k; outputs seen then reflect state k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int          s, c, ix;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  nib;

  always @(negedge clk) begin
    if (mon_en && cyc >= 1) begin
      s = cyc - 1;
      while (sb.size() > 0 && sb[0].start <= s) cur = sb.pop_front();
      c  = s % SLOT;
      ix = (s / SLOT) % 8;
      if (c < BLANK) begin
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        nib     = cur.d[ix*4 +: 4];
        exp_an  = cur.e[ix] ? (8'hFF ^ (8'h01 << ix)) : 8'hFF;
        exp_seg = font_of(nib);
        exp_dp  = !cur.p[ix];
      end
      chk($sformatf("an@%0d", s), {24'h0, an}, {24'h0, exp_an});
      chk($sformatf("seg@%0d", s), {25'h0, seg}, {25'h0, exp_seg});
      chk($sformatf("dp@%0d", s), {31'h0, dp}, {31'h0, exp_dp});
      chk($sformatf("tick@%0d", s), {31'h0, frame_tick}, {31'h0, (s % FRAME) == FRAME - 1});
    end
  end

  // Called right after a negedge; holds the offer until taken, then records when it should show.
  task automatic load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e,
                      output int acc, output int waited);
    ent_t x;
    int   b;
    data_in = d; dp_in = p; en_in = e; load_valid = 1'b1;
    waited = 0; acc = -1;
    while (!load_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!load_ready) begin
      chk("load_timeout", 32'd0, 32'd1);
    end else begin
      acc = cyc;
      b = (acc / FRAME) * FRAME + FRAME - 1;
      if (b <= acc) b += FRAME;
      x.start = b + 1; x.d = d; x.p = p; x.e = e;
      sb.push_back(x);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  int acc, waited, guard;

  initial begin
    cur.start = 0; cur.d = '0; cur.p = '0; cur.e = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'd1);
    chk("rst_ready", {31'h0, load_ready}, 32'd1);
    chk("rst_tick", {31'h0, frame_tick}, 32'd0);
    rst_n = 1'b1; mon_en = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    load(32'h76543210, 8'h01, 8'hFF, acc, waited);
    repeat (2 * FRAME + 20) @(negedge clk);

    load(32'h89ABCDEF, 8'h80, 8'hFF, acc, waited);
    chk("ready_low_pend_full", {31'h0, load_ready}, 32'd0);
    load(32'h01234567, 8'h0F, 8'hF0, acc, waited);
    chk("second_load_waited", {31'h0, waited > 0}, 32'd1);
    chk("second_accept_after_boundary", acc % FRAME, 32'd0);
    repeat (2 * FRAME + 10) @(negedge clk);

    guard = 0;
    while ((cyc % FRAME) != FRAME - 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_boundary", {31'h0, guard < 200}, 32'd1);
    load(32'hFEDCBA98, 8'hAA, 8'h55, acc, waited);
    chk("boundary_accept_cycle", acc % FRAME, FRAME - 1);
    chk("boundary_accept_nowait", waited, 32'd0);
    repeat (3 * FRAME) @(negedge clk);

    load(32'hFFFFFFFF, 8'h00, 8'h0F, acc, waited);
    repeat (2 * FRAME + 20) @(negedge clk);

    load(32'h76543210, 8'h01, 8'hFF, acc, waited);
    repeat (2 * FRAME) @(negedge clk);
    guard = 0;
    while ((cyc % FRAME) != 56 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_an", {24'h0, an}, 32'hDF);
    chk("pre_reset_seg", {25'h0, seg}, {25'h0, font_of(4'h5)});
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'h0, an}, 32'hFF);
    chk("async_rst_seg", {25'h0, seg}, 32'h7F);
    chk("async_rst_dp", {31'h0, dp}, 32'd1);
    chk("async_rst_ready", {31'h0, load_ready}, 32'd1);
    sb.delete();
    cur.start = 0; cur.d = '0; cur.p = '0; cur.e = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    repeat (FRAME + 5) @(negedge clk);
    load(32'h76543210, 8'h01, 8'hFF, acc, waited);
    repeat (2 * FRAME + 20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
